video_mode_ctrl: RTL and testbench

//  Frame-synchronous kernel/mode controller in front of fir2d, in the rx_clk domain.

---
 rtl/vmc_pkg.sv | 19 +
 rtl/video_mode_ctrl_if.sv | 17 +
 rtl/vmc_debounce.sv | 36 +++
 rtl/video_mode_ctrl.sv | 96 +++++++++
 tb/tb_video_mode_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vmc_pkg.sv
// Shared constants and default kernel tables for the video mode controller.
package vmc_pkg;
  localparam int MODE_BYPASS  = 0;
  localparam int MODE_LAPLACE = 1;
  localparam int MODE_BOX     = 2;
  localparam int ONE          = 256;  // Q8.8 unity

  // Reset contents of bank[mode][idx]; modes without a dedicated kernel fall back to identity.
  function automatic int default_coef(int mode, int idx, int ksize);
    int kk, center;
    kk     = ksize * ksize;
    center = (ksize / 2) * ksize + ksize / 2;
    case (mode)
      MODE_LAPLACE: return (idx == center) ? (kk - 1) * ONE : -ONE;
      MODE_BOX:     return ONE / kk;
      default:      return (idx == center) ? ONE : 0;
    endcase
  endfunction
endpackage

// File: rtl/video_mode_ctrl_if.sv
// Coefficient write bus into the mode controller's kernel banks.
interface video_mode_ctrl_if #(
  parameter int KSIZE     = 5,
  parameter int CW        = 16,
  parameter int NUM_MODES = 4
);
  localparam int MW = $clog2(NUM_MODES);
  localparam int IW = $clog2(KSIZE * KSIZE);

  logic          cfg_we;
  logic [MW-1:0] cfg_mode;
  logic [IW-1:0] cfg_idx;
  logic [CW-1:0] cfg_data;

  modport master (output cfg_we, cfg_mode, cfg_idx, cfg_data);
  modport slave  (input  cfg_we, cfg_mode, cfg_idx, cfg_data);
endinterface

// File: rtl/vmc_debounce.sv
// Two-flop synchroniser plus stable-level counter; pulses rise_o once per accepted 0->1.
module vmc_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  localparam int CNTW = $clog2(DEB_CYCLES + 1);

  logic [1:0]      sync;
  logic            s_q, level;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync   <= '0;
      s_q    <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      sync   <= {sync[0], d_i};
      s_q    <= sync[1];
      rise_o <= 1'b0;
      if (sync[1] != s_q) cnt <= '0;
      else if (cnt != CNTW'(DEB_CYCLES)) cnt <= cnt + 1'b1;
      // s_q has held for DEB_CYCLES samples: adopt it as the debounced level
      if (cnt == CNTW'(DEB_CYCLES) && level != s_q) begin
        level  <= s_q;
        rise_o <= s_q;
      end
    end
  end
endmodule

// File: rtl/video_mode_ctrl.sv
// Frame-synchronous kernel/mode controller for fir2d; swaps coefficient sets only on vsync.
// Define VMC_VS_WATCHDOG_EN to force a commit after WDOG_CYCLES without a vsync edge.
module video_mode_ctrl
  import vmc_pkg::*;
#(
  parameter int KSIZE       = 5,
  parameter int CW          = 16,
  parameter int NUM_MODES   = 4,
  parameter int DEB_CYCLES  = 1000000,
  parameter int VS_POL      = 1,
  parameter int WDOG_CYCLES = 4000000,
  localparam int MW = $clog2(NUM_MODES),
  localparam int KK = KSIZE * KSIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MW-1:0]      mode_sel_i,
  input  logic               step_i,
  input  logic               vs_i,
  video_mode_ctrl_if.slave   cfg,
  output logic [KK*CW-1:0]   coeffs_o,
  output logic               bypass_o,
  output logic [MW-1:0]      mode_o,
  output logic               pending_o
);
  logic signed [CW-1:0] bank [NUM_MODES][KK];
  logic [1:0][MW-1:0]   msel_sync;
  logic [MW-1:0]        msel_q, req_mode;
  logic                 step_evt, vs_q, dirty, vs_edge, wd_fire, commit, cfg_ok;

  vmc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (step_i),
    .rise_o (step_evt)
  );

  assign vs_edge   = (vs_i == 1'(VS_POL)) && (vs_q != 1'(VS_POL));
  assign pending_o = (req_mode != mode_o) || dirty;
  assign commit    = (vs_edge || wd_fire) && pending_o;
  assign cfg_ok    = cfg.cfg_we && (int'(cfg.cfg_idx) < KK) && (int'(cfg.cfg_mode) < NUM_MODES);

`ifdef VMC_VS_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  // Saturates at the limit so a request arriving late on a dead link commits at once
  assign wd_fire = (wd_cnt == WDW'(WDOG_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n || vs_edge || commit) wd_cnt <= '0;
    else if (!wd_fire)               wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = (WDOG_CYCLES < 0);  // constant 0: commits happen only on vsync
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msel_sync <= '0;
      msel_q    <= '0;
      req_mode  <= '0;
      mode_o    <= '0;
      vs_q      <= 1'(VS_POL);
      dirty     <= 1'b0;
      bypass_o  <= 1'b1;
      for (int m = 0; m < NUM_MODES; m++)
        for (int i = 0; i < KK; i++)
          bank[m][i] <= CW'(default_coef(m, i, KSIZE));
      for (int i = 0; i < KK; i++)
        coeffs_o[i*CW +: CW] <= CW'(default_coef(MODE_BYPASS, i, KSIZE));
    end else begin
      msel_sync <= {msel_sync[0], mode_sel_i};
      msel_q    <= msel_sync[1];
      vs_q      <= vs_i;

      // A switch move overrides a simultaneous button press
      if (msel_sync[1] != msel_q) req_mode <= msel_sync[1];
      else if (step_evt)
        req_mode <= (int'(req_mode) == NUM_MODES - 1) ? '0 : req_mode + 1'b1;

      if (cfg_ok) bank[cfg.cfg_mode][cfg.cfg_idx] <= cfg.cfg_data;

      // Commit reads the pre-write bank; a same-cycle write to it re-arms dirty
      if (commit) begin
        mode_o   <= req_mode;
        bypass_o <= (req_mode == '0);
        for (int i = 0; i < KK; i++)
          coeffs_o[i*CW +: CW] <= bank[req_mode][i];
        dirty    <= cfg_ok && (cfg.cfg_mode == req_mode);
      end else if (cfg_ok && cfg.cfg_mode == mode_o) begin
        dirty <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomised scoreboard bench for video_mode_ctrl against a frame-level reference model.
module tb_video_mode_ctrl;
  localparam int KSIZE = 5, CW = 16, NM = 4, MW = 2, KK = 25, W = KK * CW;
  localparam int DEB = 16, WDOG = 200, CENTER = 12;

  logic          clk = 1'b0, rst_n = 1'b0, step_i = 1'b0, vs_i = 1'b0;
  logic [MW-1:0] mode_sel_i = '0;
  logic [W-1:0]  coeffs_o;
  logic          bypass_o, pending_o;
  logic [MW-1:0] mode_o;

  video_mode_ctrl_if #(.KSIZE(KSIZE), .CW(CW), .NUM_MODES(NM)) cfg ();

  video_mode_ctrl #(.KSIZE(KSIZE), .CW(CW), .NUM_MODES(NM), .DEB_CYCLES(DEB),
                    .VS_POL(1), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .mode_sel_i(mode_sel_i), .step_i(step_i), .vs_i(vs_i),
    .cfg(cfg), .coeffs_o(coeffs_o), .bypass_o(bypass_o), .mode_o(mode_o), .pending_o(pending_o));

  always #5 clk = ~clk;

  typedef struct {
    int          mode;
    bit          bypass;
    bit          pending;
    logic [W-1:0] coeffs;
    string       tag;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   vectors = 0, errs = 0;

  // Reference model: what the user has asked for and what fir2d should be running
  logic signed [CW-1:0] mbank [NM][KK];
  logic signed [CW-1:0] act_coef [KK];
  int req, act, cur_msel, since_vs, n;
  bit dirty;

  function automatic logic signed [CW-1:0] ref_coef(int m, int i);
    if (m == 1) return (i == CENTER) ? 16'sd6144 : -16'sd256;
    if (m == 2) return 16'sd10;
    return (i == CENTER) ? 16'sd256 : 16'sd0;
  endfunction

  function automatic bit m_pending();
    return (req != act) || dirty;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < NM; m++)
      for (int i = 0; i < KK; i++) mbank[m][i] = ref_coef(m, i);
    for (int i = 0; i < KK; i++) act_coef[i] = mbank[0][i];
    req = 0; act = 0; dirty = 0; cur_msel = 0;
  endtask

  task automatic model_commit();
    if (m_pending()) begin
      act = req;
      for (int i = 0; i < KK; i++) act_coef[i] = mbank[act][i];
      dirty = 0;
    end
  endtask

  task automatic model_write(int m, int idx, logic [CW-1:0] d);
    if (idx < KK) begin
      mbank[m][idx] = d;
      if (m == act) dirty = 1;
    end
  endtask

  task automatic cmp(string tag, string f, logic [W-1:0] got, logic [W-1:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s.%s: got %0h want %0h", tag, f, got, want);
    end
  endtask

  task automatic checkpoint(string tag);
    exp_t e;
    e.mode    = act;
    e.bypass  = (act == 0);
    e.pending = m_pending();
    for (int i = 0; i < KK; i++) e.coeffs[i*CW +: CW] = act_coef[i];
    e.tag = tag;
    sb.push_back(e);
    -> chk_ev;
  endtask

  // Monitor: drains the scoreboard whenever stimulus marks a sampling point
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.tag, "mode",    W'(mode_o),    W'(e.mode));
        cmp(e.tag, "bypass",  W'(bypass_o),  W'(e.bypass));
        cmp(e.tag, "pending", W'(pending_o), W'(e.pending));
        cmp(e.tag, "coeffs",  coeffs_o,      e.coeffs);
      end
    end
  end

  task automatic tick(int k);
    repeat (k) begin
      @(negedge clk);
      since_vs++;
    end
  endtask

  task automatic cfg_write(int m, int idx, logic [CW-1:0] d);
    cfg.cfg_we = 1'b1; cfg.cfg_mode = MW'(m); cfg.cfg_idx = 5'(idx); cfg.cfg_data = d;
    tick(1);
    cfg.cfg_we = 1'b0;
    model_write(m, idx, d);
  endtask

  task automatic do_vs(bit wr, int m, int idx, logic [CW-1:0] d);
    checkpoint("pre_vs");
    vs_i = 1'b1;
    if (wr) begin
      cfg.cfg_we = 1'b1; cfg.cfg_mode = MW'(m); cfg.cfg_idx = 5'(idx); cfg.cfg_data = d;
    end
    tick(1);
    cfg.cfg_we = 1'b0;
    model_commit();
    if (wr) model_write(m, idx, d);
    since_vs = 0;
    checkpoint("post_vs");
    tick(3);
    vs_i = 1'b0;
    tick(3);
  endtask

  task automatic press();
    step_i = 1'b1; tick(DEB + 10);
    step_i = 1'b0; tick(DEB + 10);
    req = (req + 1) % NM;
  endtask

  task automatic set_msel(int m);
    mode_sel_i = MW'(m);
    tick(6);
    if (m != cur_msel) req = m;
    cur_msel = m;
  endtask

  task automatic keepalive();
    if (since_vs > 60) do_vs(1'b0, 0, 0, '0);
  endtask

  initial begin
    int op, m, idx;
    logic [CW-1:0] d;
    cfg.cfg_we = 1'b0; cfg.cfg_mode = '0; cfg.cfg_idx = '0; cfg.cfg_data = '0;
    model_reset();
    since_vs = 0;

    // Power-on reset
    tick(3); rst_n = 1'b1; tick(10);
    checkpoint("reset");

    // Reset mid-operation drops queued writes and requests
    cfg_write(0, CENTER, 16'd1000);
    set_msel(3);
    rst_n = 1'b0; mode_sel_i = '0; tick(2); rst_n = 1'b1;
    model_reset(); since_vs = 0;
    tick(5);
    checkpoint("reset_mid");

    // Debounced step to Laplace, committed on vsync
    press();
    checkpoint("step_pre");
    do_vs(1'b0, 0, 0, '0);

    // Bounce shorter than the debounce window
    do_vs(1'b0, 0, 0, '0);
    for (int b = 0; b < 4; b++) begin
      step_i = 1'b1; tick($urandom_range(1, 8));
      step_i = 1'b0; tick($urandom_range(1, 8));
    end
    tick(DEB + 10);
    checkpoint("bounce");

    // Write to the active bank waits for the next frame
    do_vs(1'b0, 0, 0, '0);
    cfg_write(1, CENTER, 16'd512);
    checkpoint("cfg_active");
    do_vs(1'b0, 0, 0, '0);

    // Switch and step land on the same cycle: switch wins
    set_msel(3); set_msel(0);
    do_vs(1'b0, 0, 0, '0);
    step_i = 1'b1; tick(DEB + 2);
    mode_sel_i = 2'd2; tick(DEB + 10);
    step_i = 1'b0; tick(DEB + 10);
    req = 2; cur_msel = 2;
    checkpoint("sw_vs_step");
    do_vs(1'b0, 0, 0, '0);

    // Write into the incoming bank on the commit cycle lands one frame later
    set_msel(1);
    do_vs(1'b1, 1, CENTER, 16'd777);
    do_vs(1'b0, 0, 0, '0);

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      keepalive();
      op  = $urandom_range(0, 3);
      m   = $urandom_range(0, NM - 1);
      idx = $urandom_range(0, 31);
      d   = CW'($urandom);
      case (op)
        0: cfg_write(m, idx, d);
        1: press();
        2: set_msel(m);
        default: do_vs(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? req : m, idx, d);
      endcase
      checkpoint("rand");
    end

    // No video source
    set_msel(2); set_msel(3); set_msel(0);
    do_vs(1'b0, 0, 0, '0);
`ifdef VMC_VS_WATCHDOG_EN
    vs_i = 1'b1; tick(3); n = 3;
    vs_i = 1'b0; mode_sel_i = 2'd1; req = 1; cur_msel = 1;
    while (mode_o != 2'd1 && n < 3 * WDOG) begin
      tick(1);
      n++;
    end
    vectors++;
    if (n < WDOG - 3 || n > WDOG + 6) begin
      errs++;
      $display("FAIL wdog.latency: got %0d cycles want %0d..%0d", n, WDOG - 3, WDOG + 6);
    end
    model_commit();
    checkpoint("wdog");
`else
    set_msel(1);
    tick(10000);
    checkpoint("no_wdog");
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
